alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Pipelined add/sub/and/xor ALU with valid/ready handshake on both sides and
// registered condition codes; one (STAGES=1) or two (STAGES=2) register stages.
module alu_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpXor = 2'b11
  } aluOpT;

  logic             outFree;
  logic             accept;
  logic             exLoad;
  aluOpT            exOp;
  logic [WIDTH-1:0] exA;
  logic [WIDTH-1:0] exB;
  logic             exSetCc;

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outResult_q, outResult_d;
  logic             outOvf_q, outOvf_d;
  logic             ccZf_q, ccZf_d;
  logic             ccSf_q, ccSf_d;
  logic             ccOf_q, ccOf_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] aluRes;
  logic             aluOvf;

  assign outFree = !outValid_q || out_ready;
  assign accept  = in_valid && in_ready;

  if (WIDTH < 8 || WIDTH > 64) begin : gBadWidth
    $error("alu_pipe: WIDTH must be in 8..64");
  end

  if (STAGES == 1) begin : gOneStage
    assign in_ready = !rst && outFree;
    assign exLoad   = accept;
    assign exOp     = aluOpT'(in_op);
    assign exA      = in_a;
    assign exB      = in_b;
    assign exSetCc  = in_set_cc;
  end else if (STAGES == 2) begin : gTwoStage
    logic             s1Valid_q, s1Valid_d;
    aluOpT            s1Op_q, s1Op_d;
    logic [WIDTH-1:0] s1A_q, s1A_d;
    logic [WIDTH-1:0] s1B_q, s1B_d;
    logic             s1SetCc_q, s1SetCc_d;

    // Operand stage may refill in the same cycle it hands off downstream.
    assign in_ready = !rst && (!s1Valid_q || outFree);
    assign exLoad   = s1Valid_q && outFree;
    assign exOp     = s1Op_q;
    assign exA      = s1A_q;
    assign exB      = s1B_q;
    assign exSetCc  = s1SetCc_q;

    always_comb begin
      s1Valid_d = s1Valid_q;
      s1Op_d    = s1Op_q;
      s1A_d     = s1A_q;
      s1B_d     = s1B_q;
      s1SetCc_d = s1SetCc_q;
      if (accept) begin
        s1Valid_d = 1'b1;
        s1Op_d    = aluOpT'(in_op);
        s1A_d     = in_a;
        s1B_d     = in_b;
        s1SetCc_d = in_set_cc;
      end else if (outFree) begin
        s1Valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1Valid_q <= 1'b0;
        s1Op_q    <= OpAdd;
        s1A_q     <= '0;
        s1B_q     <= '0;
        s1SetCc_q <= 1'b0;
      end else begin
        s1Valid_q <= s1Valid_d;
        s1Op_q    <= s1Op_d;
        s1A_q     <= s1A_d;
        s1B_q     <= s1B_d;
        s1SetCc_q <= s1SetCc_d;
      end
    end
  end else begin : gBadStages
    $error("alu_pipe: STAGES must be 1 or 2");
  end

  always_comb begin
    sum    = exA + exB;
    diff   = exA - exB;
    aluRes = '0;
    aluOvf = 1'b0;
    unique case (exOp)
      OpAdd: begin
        aluRes = sum;
        aluOvf = (exA[WIDTH-1] == exB[WIDTH-1]) && (sum[WIDTH-1] != exA[WIDTH-1]);
      end
      OpSub: begin
        aluRes = diff;
        aluOvf = (exA[WIDTH-1] != exB[WIDTH-1]) && (diff[WIDTH-1] != exA[WIDTH-1]);
      end
      OpAnd: aluRes = exA & exB;
      OpXor: aluRes = exA ^ exB;
    endcase
  end

  always_comb begin
    outValid_d  = outValid_q;
    outResult_d = outResult_q;
    outOvf_d    = outOvf_q;
    ccZf_d      = ccZf_q;
    ccSf_d      = ccSf_q;
    ccOf_d      = ccOf_q;
    if (exLoad) begin
      outValid_d  = 1'b1;
      outResult_d = aluRes;
      outOvf_d    = aluOvf;
      if (exSetCc) begin
        ccZf_d = (aluRes == '0);
        ccSf_d = aluRes[WIDTH-1];
        ccOf_d = aluOvf;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      outResult_q <= '0;
      outOvf_q    <= 1'b0;
      ccZf_q      <= 1'b1;
      ccSf_q      <= 1'b0;
      ccOf_q      <= 1'b0;
    end else begin
      outValid_q  <= outValid_d;
      outResult_q <= outResult_d;
      outOvf_q    <= outOvf_d;
      ccZf_q      <= ccZf_d;
      ccSf_q      <= ccSf_d;
      ccOf_q      <= ccOf_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_result = outResult_q;
  assign out_ovf    = outOvf_q;
  assign cc_zf      = ccZf_q;
  assign cc_sf      = ccSf_q;
  assign cc_of      = ccOf_q;

endmodule
